operand_issue: RTL and testbench

OPERAND_ISSUE -- requirements
Module: operand_issue

---
 rtl/operand_issue.sv | 161 ++++++++++++++++
 tb/tb_operand_issue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue.sv
// operand_issue: decodes register usage of an RV64I instruction, tracks
// in-flight destinations in a busy scoreboard, stalls on RAW/WAW hazards,
// resolves source operands (with writeback bypass) and holds the issued
// bundle in a one-entry output register under valid/ready handshaking.
module operand_issue #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  input  logic [XLEN-1:0] i_rs1_value,
  input  logic [XLEN-1:0] i_rs2_value,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_rs1_val,
  output logic [XLEN-1:0] o_rs2_val,
  output logic [4:0]      o_rd,
  output logic            o_rd_we,
  input  logic            i_flush
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  // x0 is never busy, so the scoreboard only stores indices 1..NREGS-1
  logic [NREGS-1:1] busy_q;

  logic [4:0]      rs1, rs2, rd;
  logic            use_rs1, use_rs2, use_rd;
  logic            hazard;
  logic            accept, issue;
  logic [XLEN-1:0] rs1_sel, rs2_sel;

  assign rs1        = i_instr[19:15];
  assign rs2        = i_instr[24:20];
  assign rd         = i_instr[11:7];
  assign o_rs1_addr = rs1;
  assign o_rs2_addr = rs2;

  // Scoreboard lookup for a 5-bit index; indices outside 1..NREGS-1 are never busy
  function automatic logic busy_of(input logic [NREGS-1:1] b, input logic [4:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (idx == 5'(i)) hit = b[i];
    end
    return hit;
  endfunction

  // A nonzero index is pending if busy without a releasing writeback this
  // cycle, or if it is the destination of the bundle currently held
  function automatic logic pending(input logic [NREGS-1:1] b, input logic [4:0] idx,
                                   input logic wbv, input logic [4:0] wbrd,
                                   input logic hv, input logic hwe, input logic [4:0] hrd);
    return (idx != 5'd0) &&
           ((busy_of(b, idx) && !(wbv && wbrd == idx)) || (hv && hwe && hrd == idx));
  endfunction

  // Opcode decode into register-usage flags
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (i_instr[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: use_rd = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM32: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_OP, OP_OP32: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazard detection, handshake and operand selection with writeback bypass
  always_comb begin
    hazard = (use_rs1 && pending(busy_q, rs1, i_wb_valid, i_wb_rd, o_valid, o_rd_we, o_rd)) ||
             (use_rs2 && pending(busy_q, rs2, i_wb_valid, i_wb_rd, o_valid, o_rd_we, o_rd)) ||
             (use_rd  && pending(busy_q, rd,  i_wb_valid, i_wb_rd, o_valid, o_rd_we, o_rd));
    o_ready = !i_reset && !i_flush && !hazard && (!o_valid || i_ready);
    accept  = i_valid && o_ready;
    issue   = o_valid && i_ready && !i_flush;

    if (!use_rs1 || rs1 == 5'd0)          rs1_sel = '0;
    else if (i_wb_valid && i_wb_rd == rs1) rs1_sel = i_wb_data;
    else                                   rs1_sel = i_rs1_value;

    if (!use_rs2 || rs2 == 5'd0)          rs2_sel = '0;
    else if (i_wb_valid && i_wb_rd == rs2) rs2_sel = i_wb_data;
    else                                   rs2_sel = i_rs2_value;
  end

  // Output bundle register: load on accept, drop on issue or flush
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      o_valid   <= 1'b0;
      o_instr   <= '0;
      o_pc      <= '0;
      o_rs1_val <= '0;
      o_rs2_val <= '0;
      o_rd      <= '0;
      o_rd_we   <= 1'b0;
    end else if (accept) begin
      o_valid   <= 1'b1;
      o_instr   <= i_instr;
      o_pc      <= i_pc;
      o_rs1_val <= rs1_sel;
      o_rs2_val <= rs2_sel;
      o_rd      <= use_rd ? rd : 5'd0;
      o_rd_we   <= use_rd && (rd != 5'd0);
    end else if (issue || i_flush) begin
      o_valid <= 1'b0;
    end
  end

  // Busy scoreboard: writeback clears, issue sets, set wins on a collision
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: the scoreboard is a small flop vector, not a RAM, so it is reset along with the bundle.
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (issue && o_rd_we && o_rd == 5'(i))
          busy_q[i] <= 1'b1;
        else if (i_wb_valid && i_wb_rd == 5'(i))
          busy_q[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_issue.sv
// Testbench for operand_issue: directed scenarios then randomized traffic,
// checked by a queue-based scoreboard fed from a reference model.
module tb_operand_issue;

  localparam int XLEN = 64;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic [4:0]      o_rs1_addr, o_rs2_addr;
  logic [XLEN-1:0] i_rs1_value, i_rs2_value;
  logic            i_wb_valid;
  logic [4:0]      i_wb_rd;
  logic [XLEN-1:0] i_wb_data;
  logic            o_valid;
  logic            i_ready;
  logic [31:0]     o_instr;
  logic [XLEN-1:0] o_pc, o_rs1_val, o_rs2_val;
  logic [4:0]      o_rd;
  logic            o_rd_we;
  logic            i_flush;

  operand_issue #(.XLEN(XLEN), .NREGS(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_value(i_rs1_value), .i_rs2_value(i_rs2_value),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc),
    .o_rs1_val(o_rs1_val), .o_rs2_val(o_rs2_val), .o_rd(o_rd), .o_rd_we(o_rd_we),
    .i_flush(i_flush)
  );

  always #5 i_clk = ~i_clk;

  // Architectural register file model; commits writebacks at the clock edge
  logic [XLEN-1:0] rf [32];
  assign i_rs1_value = (o_rs1_addr == 5'd0) ? '0 : rf[o_rs1_addr];
  assign i_rs2_value = (o_rs2_addr == 5'd0) ? '0 : rf[o_rs2_addr];

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
    logic            we;
    logic            use_rd;
  } bundle_t;

  bundle_t sb_q[$];

  // Reference state: set of in-flight destinations and the held bundle
  bit [31:0] busy_m;
  bit        m_valid;
  bit [4:0]  m_rd;
  bit        m_we;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Register usage straight from the opcode table
  function automatic void uses(input logic [6:0] op, output bit u1, output bit u2, output bit ud);
    u1 = 0; u2 = 0; ud = 0;
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: ud = 1;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011: begin u1 = 1; ud = 1; end
      7'b1100011, 7'b0100011: begin u1 = 1; u2 = 1; end
      7'b0110011, 7'b0111011: begin u1 = 1; u2 = 1; ud = 1; end
      default: ;
    endcase
  endfunction

  function automatic bit pend(input logic [4:0] r);
    if (r == 0) return 0;
    if (busy_m[r] && !(i_wb_valid && i_wb_rd == r)) return 1;
    return m_valid && m_we && (m_rd == r);
  endfunction

  function automatic logic [XLEN-1:0] operand(input bit u, input logic [4:0] r);
    if (!u || r == 0) return '0;
    if (i_wb_valid && i_wb_rd == r) return i_wb_data;
    return rf[r];
  endfunction

  function automatic logic [31:0] add_i(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] addi_i(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  // One cycle: drive at posedge+1, evaluate model at negedge+1, commit rf at next posedge+1
  task automatic step(input bit v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                      input bit rdy, input bit fl, input bit wbv, input logic [4:0] wbrd,
                      input logic [XLEN-1:0] wbd, output bit got_ready);
    bit u1, u2, ud, hz, exp_ready, iss, acc;
    bundle_t b;
    i_valid = v; i_instr = ins; i_pc = pc; i_ready = rdy; i_flush = fl;
    i_wb_valid = wbv; i_wb_rd = wbrd; i_wb_data = wbd;
    @(negedge i_clk);
    #1;
    uses(ins[6:0], u1, u2, ud);
    hz = (u1 && pend(ins[19:15])) || (u2 && pend(ins[24:20])) || (ud && pend(ins[11:7]));
    exp_ready = !i_reset && !fl && !hz && (!m_valid || rdy);
    got_ready = o_ready;
    check("o_ready", o_ready, exp_ready);
    check("rs1_addr", o_rs1_addr, ins[19:15]);
    check("rs2_addr", o_rs2_addr, ins[24:20]);
    iss = m_valid && rdy && !fl;
    acc = v && exp_ready;
    if (wbv && wbrd != 0) busy_m[wbrd] = 0;
    if (iss && m_we) busy_m[m_rd] = 1;
    if (acc) begin
      b.instr = ins; b.pc = pc;
      b.rs1 = operand(u1, ins[19:15]);
      b.rs2 = operand(u2, ins[24:20]);
      b.use_rd = ud; b.rd = ins[11:7];
      b.we = ud && (ins[11:7] != 0);
      sb_q.push_back(b);
      m_valid = 1; m_rd = b.rd; m_we = b.we;
    end else if (iss || fl) begin
      m_valid = 0;
    end
    @(posedge i_clk);
    #1;
    if (wbv && wbrd != 0) rf[wbrd] = wbd;
  endtask

  task automatic idle(input bit rdy, output bit r);
    step(0, 32'h0000_0013, '0, rdy, 0, 0, 5'd0, '0, r);
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear without a clock
  task automatic reset_pulse();
    #2;
    i_reset = 1; i_valid = 0; i_flush = 0; i_wb_valid = 0;
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_instr", o_instr, 0);
    check("rst_o_pc", o_pc, 0);
    check("rst_o_rs1", o_rs1_val, 0);
    check("rst_o_rs2", o_rs2_val, 0);
    check("rst_o_rd", {o_rd_we, o_rd}, 0);
    check("rst_o_ready", o_ready, 0);
    busy_m = 0; m_valid = 0; sb_q.delete();
    @(posedge i_clk);
    #1;
    i_reset = 0;
  endtask

  // Monitor: compares the presented bundle against the scoreboard head
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        if (o_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_bundle", o_valid, 0);
          end else begin
            check("o_instr", o_instr, sb_q[0].instr);
            check("o_pc", o_pc, sb_q[0].pc);
            check("o_rs1_val", o_rs1_val, sb_q[0].rs1);
            check("o_rs2_val", o_rs2_val, sb_q[0].rs2);
            check("o_rd_we", o_rd_we, sb_q[0].we);
            if (sb_q[0].use_rd) check("o_rd", o_rd, sb_q[0].rd);
            if (i_ready || i_flush) void'(sb_q.pop_front());
          end
        end else begin
          check("missing_bundle", sb_q.size(), 0);
        end
      end
    end
  end

  initial begin
    bit r;
    logic [6:0] ops [14];
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
            7'b0011011, 7'b1100011, 7'b0100011, 7'b0110011, 7'b0111011, 7'b0001111,
            7'b1110011, 7'b1111111};
    for (int i = 0; i < 32; i++) rf[i] = XLEN'(i);
    busy_m = 0; m_valid = 0; m_rd = 0; m_we = 0;
    i_reset = 1; i_valid = 0; i_instr = 0; i_pc = 0; i_ready = 0; i_flush = 0;
    i_wb_valid = 0; i_wb_rd = 0; i_wb_data = 0;
    #1;
    check("init_o_valid", o_valid, 0);
    check("init_o_ready", o_ready, 0);
    check("init_o_rd_we", o_rd_we, 0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset = 0;

    // ADD x3,x1,x2 then issue; dependent ADDI waits for x3 writeback with bypass
    step(1, add_i(5'd3, 5'd1, 5'd2), 64'h100, 1, 0, 0, 5'd0, '0, r);
    check("add_valid", o_valid, 1);
    check("add_rs1", o_rs1_val, 1);
    check("add_rs2", o_rs2_val, 2);
    check("add_rd", o_rd, 3);
    check("add_we", o_rd_we, 1);
    step(1, addi_i(5'd4, 5'd3, 12'd5), 64'h104, 1, 0, 0, 5'd0, '0, r);
    check("raw_stall_held", r, 0);
    step(1, addi_i(5'd4, 5'd3, 12'd5), 64'h104, 1, 0, 0, 5'd0, '0, r);
    check("raw_stall_busy", r, 0);
    step(1, addi_i(5'd4, 5'd3, 12'd5), 64'h104, 1, 0, 1, 5'd3, 64'h77, r);
    check("bypass_accept", r, 1);
    check("bypass_rs1", o_rs1_val, 64'h77);
    idle(1, r);

    // Issue ADD x5 with simultaneous x5 writeback: busy must stay set
    step(1, add_i(5'd5, 5'd1, 5'd2), 64'h200, 1, 0, 0, 5'd0, '0, r);
    step(0, 32'h0000_0013, '0, 1, 0, 1, 5'd5, 64'h55, r);
    step(1, add_i(5'd6, 5'd5, 5'd1), 64'h204, 1, 0, 0, 5'd0, '0, r);
    check("set_wins_stall", r, 0);
    step(1, add_i(5'd6, 5'd5, 5'd1), 64'h204, 1, 0, 1, 5'd5, 64'h56, r);
    check("set_wins_release", r, 1);
    idle(1, r);
    step(0, 32'h0000_0013, '0, 1, 0, 1, 5'd6, 64'h66, r);

    // Hold for 3 cycles then flush: no busy bit for x7
    step(1, add_i(5'd7, 5'd1, 5'd2), 64'h300, 0, 0, 0, 5'd0, '0, r);
    for (int i = 0; i < 3; i++) begin
      idle(0, r);
      check("hold_instr", o_instr, add_i(5'd7, 5'd1, 5'd2));
    end
    step(0, 32'h0000_0013, '0, 0, 1, 0, 5'd0, '0, r);
    check("flush_no_accept", r, 0);
    check("flush_valid", o_valid, 0);
    step(1, add_i(5'd8, 5'd7, 5'd0), 64'h304, 1, 0, 0, 5'd0, '0, r);
    check("flush_no_busy", r, 1);
    idle(1, r);
    step(0, 32'h0000_0013, '0, 1, 0, 1, 5'd8, 64'h88, r);

    // ADD x0,x0,x0 then reset mid-hold
    step(1, add_i(5'd0, 5'd0, 5'd0), 64'h400, 0, 0, 0, 5'd0, '0, r);
    check("x0_no_stall", r, 1);
    check("x0_we", o_rd_we, 0);
    check("x0_ops", {o_rs1_val, o_rs2_val} == '0, 1);
    idle(0, r);
    reset_pulse();
    step(1, add_i(5'd9, 5'd3, 5'd5), 64'h500, 1, 0, 0, 5'd0, '0, r);
    check("post_reset_no_busy", r, 1);

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      logic [4:0]  wr;
      bit          wv;
      ins = {$urandom_range(127, 0) == 0 ? 7'h20 : 7'h00,
             5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
             3'($urandom), 5'($urandom_range(7, 0)), ops[$urandom_range(13, 0)]};
      wv = ($urandom_range(99, 0) < 45);
      wr = 5'($urandom_range(7, 0));
      if (busy_m != 0 && $urandom_range(3, 0) != 0) begin
        for (int k = 0; k < 32; k++) begin
          wr = 5'($urandom_range(31, 0));
          if (busy_m[wr]) break;
        end
      end
      if (n == 300) reset_pulse();
      step($urandom_range(99, 0) < 70, ins, {$urandom, $urandom},
           $urandom_range(99, 0) < 75, $urandom_range(99, 0) < 5,
           wv, wr, {$urandom, $urandom}, r);
    end
    idle(1, r);
    idle(1, r);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
